// File: rtl/pim_cmd_dispatcher_pkg.sv
// types: address width and dispatcher state encoding shared by the PIM command path
package types;
   localparam int LEN = 16;
   typedef enum logic [1:0] {DISP_IDLE, DISP_START, DISP_WAIT} disp_state_t;
endpackage

// File: rtl/pim_cmd_dispatcher_fifo.sv
// pim_cmd_fifo: DEPTH-entry synchronous command FIFO with occupancy count
module pim_cmd_fifo
   import types::*;
#(
   parameter int WIDTH = 3 * LEN,
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic                   pop,
   input  logic [WIDTH-1:0]       wdata,
   output logic [WIDTH-1:0]       rdata,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);
   localparam int AW = $clog2(DEPTH);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wp;
   logic [AW-1:0]    rp;
   logic             do_push;
   logic             do_pop;
   assign full    = count == (AW + 1)'(DEPTH);
   assign empty   = count == '0;
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem[rp];
   // pointers wrap naturally because DEPTH is a power of two
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         wp    <= '0;
         rp    <= '0;
         count <= '0;
      end else begin
         wp    <= do_push ? wp + 1'b1 : wp;
         rp    <= do_pop ? rp + 1'b1 : rp;
         count <= count + (AW + 1)'(do_push) - (AW + 1)'(do_pop);
      end
   // storage needs no reset: an entry is only read after it has been written
   always_ff @(posedge clk)
      if (do_push) mem[wp] <= wdata;
endmodule

// File: rtl/pim_cmd_dispatcher.sv
// pim_cmd_dispatcher: queues host matmul commands and issues them one at a time to memory
module pim_cmd_dispatcher
   import types::*;
#(
   parameter int ADDR_W       = LEN,
   parameter int DEPTH        = 4,
   parameter int START_CYCLES = 1,
   parameter int TIMEOUT      = 4096
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   cmd_valid,
   output logic                   cmd_ready,
   input  logic [ADDR_W-1:0]      cmd_src1,
   input  logic [ADDR_W-1:0]      cmd_src2,
   input  logic [ADDR_W-1:0]      cmd_dst,
   output logic [ADDR_W-1:0]      mem_src1_addr,
   output logic [ADDR_W-1:0]      mem_src2_addr,
   output logic [ADDR_W-1:0]      mem_dst_addr,
   output logic                   mem_start,
   input  logic                   mem_done,
   output logic                   busy,
   output logic [$clog2(DEPTH):0] queue_count,
   output logic [15:0]            cmds_done,
   output logic                   err_timeout,
   input  logic                   err_clr
);
   localparam int SW = START_CYCLES > 1 ? $clog2(START_CYCLES) : 1;
   localparam int TW = $clog2(TIMEOUT) + 1;
   disp_state_t         state;
   logic [SW-1:0]       start_cnt;
   logic [TW-1:0]       to_cnt;
   logic [3*ADDR_W-1:0] head;
   logic                full;
   logic                empty;
   logic                push;
   logic                pop;
   logic                done;
   logic                timeout;
   assign cmd_ready = rst && !full;
   assign push      = cmd_valid && cmd_ready;
   assign pop       = state == DISP_IDLE && !empty;
   assign done      = state != DISP_IDLE && mem_done;
   assign timeout   = state != DISP_IDLE && !mem_done && to_cnt == TW'(TIMEOUT - 1);
   assign busy      = state != DISP_IDLE || !empty;
   pim_cmd_fifo #(.WIDTH(3 * ADDR_W), .DEPTH(DEPTH)) u_fifo (
      .clk,
      .rst,
      .push,
      .pop,
      .wdata({cmd_src1, cmd_src2, cmd_dst}),
      .rdata(head),
      .full,
      .empty,
      .count(queue_count)
   );
   // sequencing: issue from the queue, hold start, then wait for done or give up on timeout
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state     <= DISP_IDLE;
         mem_start <= 1'b0;
         start_cnt <= '0;
         to_cnt    <= '0;
      end else if (done || timeout) begin
         state     <= DISP_IDLE;
         mem_start <= 1'b0;
      end else if (pop) begin
         state     <= DISP_START;
         mem_start <= 1'b1;
         start_cnt <= SW'(START_CYCLES - 1);
         to_cnt    <= '0;
      end else if (state != DISP_IDLE) begin
         to_cnt <= to_cnt + 1'b1;
         if (state == DISP_START) begin
            state     <= start_cnt == '0 ? DISP_WAIT : DISP_START;
            mem_start <= start_cnt != '0;
            start_cnt <= start_cnt - 1'b1;
         end
      end
   // issued-command address latch, completion count and sticky timeout flag (set beats clear)
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         mem_src1_addr <= '0;
         mem_src2_addr <= '0;
         mem_dst_addr  <= '0;
         cmds_done     <= '0;
         err_timeout   <= 1'b0;
      end else begin
         if (pop) {mem_src1_addr, mem_src2_addr, mem_dst_addr} <= head;
         if (done) cmds_done <= cmds_done + 1'b1;
         if (timeout) err_timeout <= 1'b1;
         else if (err_clr) err_timeout <= 1'b0;
      end
endmodule
